// File: rtl/pulse_sync_mc_pkg.sv
// Shared constants and helpers for the pulse_sync_mc multi-channel event capture block.
package pulse_sync_mc_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Wide enough for FILT_CYC up to 15.
    localparam int FILT_CNT_W = 4;

    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_sync_mc_ch.sv
// One capture channel: synchroniser, optional glitch filter, edge detect, pulse, pending count, overflow.
// Define PULSE_SYNC_MC_FILT_EN to build the stability filter between synchroniser and edge history.
module pulse_sync_mc_ch
    import pulse_sync_mc_pkg::*;
#(
    parameter int SYNC_STG = 2,
    parameter int CNT_W    = 4,
    parameter int FILT_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             async_in,
    input  logic [1:0]       mode,
    input  logic             grant,
    input  logic             ovf_clr,
    output logic             evt_pul,
    output logic [CNT_W-1:0] pend,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    if (SYNC_STG < 2 || SYNC_STG > 4 || CNT_W < 1 || FILT_CYC < 1 || FILT_CYC > 15) begin : g_bad_param
        $error("pulse_sync_mc_ch: parameter out of range");
    end

    logic [SYNC_STG-1:0] sync_q;
    logic                s;
    logic                lvl;
    logic                h;
    logic                rise;
    logic                fall;
    logic                det;
    logic                ovf_set;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STG-2:0], async_in};
    end

    assign s = sync_q[SYNC_STG-1];

`ifdef PULSE_SYNC_MC_FILT_EN
    logic [FILT_CNT_W-1:0] filt_cnt;
    logic                  filt_lvl;

    // Level follows s only after s has disagreed with it for FILT_CYC consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_lvl <= 1'b0;
            filt_cnt <= '0;
        end else if (s != filt_lvl) begin
            if (filt_cnt == FILT_CNT_W'(FILT_CYC - 1)) begin
                filt_lvl <= s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = s;
`endif

    // h tracks regardless of mode so enabling a channel never sees a stale edge.
    always_ff @(posedge clk) begin
        if (rst) h <= 1'b0;
        else     h <= lvl;
    end

    assign rise = lvl & ~h;
    assign fall = ~lvl & h;
    assign det  = ((mode == MODE_RISE || mode == MODE_BOTH) && rise) ||
                  ((mode == MODE_FALL || mode == MODE_BOTH) && fall);

    always_ff @(posedge clk) begin
        if (rst) evt_pul <= 1'b0;
        else     evt_pul <= det;
    end

    assign ovf_set = evt_pul && !grant && (pend == PEND_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else begin
            case ({evt_pul, grant})
                2'b10:   if (pend != PEND_MAX) pend <= pend + 1'b1;
                2'b01:   pend <= pend - 1'b1;
                default: pend <= pend;
            endcase
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_sync_mc.sv
// Multi-channel pulse synchroniser with round-robin valid/ready event drain.
// Define PULSE_SYNC_MC_FILT_EN to add a FILT_CYC-cycle glitch filter in every channel.
module pulse_sync_mc
    import pulse_sync_mc_pkg::*;
#(
    parameter  int NCH      = 4,
    parameter  int SYNC_STG = 2,
    parameter  int CNT_W    = 4,
    parameter  int FILT_CYC = 3,
    localparam int CH_W     = chw(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    async_in,
    input  logic [2*NCH-1:0]  mode,
    output logic [NCH-1:0]    evt_pul,
    output logic              evt_vld,
    output logic [CH_W-1:0]   evt_ch,
    input  logic              evt_rdy,
    output logic [NCH-1:0]    ovf,
    input  logic [NCH-1:0]    ovf_clr
);

    if (NCH < 1 || NCH > 16) begin : g_bad_nch
        $error("pulse_sync_mc: NCH out of range");
    end

    logic [CNT_W-1:0] pend [NCH];
    logic [NCH-1:0]   nz;
    logic [NCH-1:0]   grant;
    logic             lock;
    logic             hs;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pulse_sync_mc_ch #(
            .SYNC_STG (SYNC_STG),
            .CNT_W    (CNT_W),
            .FILT_CYC (FILT_CYC)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .async_in (async_in[i]),
            .mode     (mode[2*i +: 2]),
            .grant    (grant[i]),
            .ovf_clr  (ovf_clr[i]),
            .evt_pul  (evt_pul[i]),
            .pend     (pend[i]),
            .ovf      (ovf[i])
        );
        assign nz[i]    = |pend[i];
        assign grant[i] = hs && (int'(evt_ch) == i);
    end

    assign evt_vld = lock | (|nz);
    assign hs      = evt_vld & evt_rdy;

    // Once offered and stalled, the channel stays frozen until it is taken.
    always_ff @(posedge clk) begin
        if (rst)          lock <= 1'b0;
        else if (hs)      lock <= 1'b0;
        else if (evt_vld) lock <= 1'b1;
    end

    if (NCH == 1) begin : g_single
        assign evt_ch = '0;
    end else begin : g_rr
        logic [CH_W-1:0] ptr;
        logic [CH_W-1:0] lock_ch;
        logic [CH_W-1:0] sel;

        // Scanning downward lets the candidate nearest the pointer overwrite the others.
        always_comb begin
            int idx;
            idx = 0;
            sel = '0;
            for (int k = NCH - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % NCH;
                if (nz[idx]) sel = CH_W'(idx);
            end
        end

        assign evt_ch = lock ? lock_ch : sel;

        always_ff @(posedge clk) begin
            if (rst) begin
                ptr     <= '0;
                lock_ch <= '0;
            end else if (hs) begin
                ptr     <= CH_W'((int'(evt_ch) + 1) % NCH);
            end else if (evt_vld) begin
                lock_ch <= evt_ch;
            end
        end
    end

endmodule

// File: tb/tb_pulse_sync_mc.sv
// Directed self-checking bench for pulse_sync_mc (NCH=4, SYNC_STG=2, CNT_W=2).
// Filter scenario is compiled only when PULSE_SYNC_MC_FILT_EN is defined.
module tb_pulse_sync_mc;
    import pulse_sync_mc_pkg::*;

    localparam int NCH      = 4;
    localparam int SYNC_STG = 2;
    localparam int CNT_W    = 2;
    localparam int FILT_CYC = 3;
`ifdef PULSE_SYNC_MC_FILT_EN
    localparam int FL = FILT_CYC;
`else
    localparam int FL = 0;
`endif
    // Pulse is high in the cycle after edge k+LAT when the input changes before edge k.
    localparam int LAT    = SYNC_STG + FL;
    localparam int SETTLE = LAT + 3;
    localparam int GAP    = FL + 5;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   async_in;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]   evt_pul;
    logic             evt_vld;
    logic [1:0]       evt_ch;
    logic             evt_rdy;
    logic [NCH-1:0]   ovf;
    logic [NCH-1:0]   ovf_clr;

    int checks   = 0;
    int failures = 0;
    int got[$];

    pulse_sync_mc #(
        .NCH      (NCH),
        .SYNC_STG (SYNC_STG),
        .CNT_W    (CNT_W),
        .FILT_CYC (FILT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .async_in (async_in),
        .mode     (mode),
        .evt_pul  (evt_pul),
        .evt_vld  (evt_vld),
        .evt_ch   (evt_ch),
        .evt_rdy  (evt_rdy),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (evt_vld && evt_rdy) got.push_back(int'(evt_ch));
            tick();
        end
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode[2*ch +: 2] = m;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        async_in = '0;
        evt_rdy  = 1'b0;
        ovf_clr  = '0;
        tick();
        tick();
        rst = 1'b0;
        got.delete();
    endtask

    task automatic watch_pulse(input int ch, input int hold, input int exp, input int n, input string name);
        for (int j = 0; j < n; j++) begin
            tick();
            if (j == hold - 1) async_in[ch] = 1'b0;
            checks++;
            if (evt_pul[ch] !== (j == exp)) begin
                failures++;
                $display("FAIL %s cycle=%0d evt_pul=%0b exp=%0b", name, j, evt_pul[ch], (j == exp));
            end
        end
    endtask

    task automatic test_reset();
        mode = '0;
        do_reset();
        checks++; if (evt_pul !== 4'b0) begin failures++; $display("FAIL rst_pul got=%b exp=0000", evt_pul); end
        checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", evt_vld); end
        checks++; if (evt_ch !== 2'd0)  begin failures++; $display("FAIL rst_ch got=%0d exp=0", evt_ch); end
        checks++; if (ovf !== 4'b0)     begin failures++; $display("FAIL rst_ovf got=%b exp=0000", ovf); end
        mode = '1;
        run(SETTLE);
        checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL idle_vld got=%b exp=0", evt_vld); end
        // Input held high through reset release must show up as a rising edge.
        rst = 1'b1;
        mode = '0;
        set_mode(1, MODE_RISE);
        async_in[1] = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        watch_pulse(1, 1000, LAT, LAT + 3, "pwrup_pul");
    endtask

    task automatic test_single();
        mode = '0;
        do_reset();
        set_mode(0, MODE_RISE);
        async_in[0] = 1'b1;
        watch_pulse(0, 1000, LAT, LAT + 3, "t1_pul");
        checks++; if (evt_vld !== 1'b1) begin failures++; $display("FAIL t1_vld got=%b exp=1", evt_vld); end
        checks++; if (evt_ch !== 2'd0)  begin failures++; $display("FAIL t1_ch got=%0d exp=0", evt_ch); end
        evt_rdy = 1'b1;
        run(1);
        evt_rdy = 1'b0;
        checks++;
        if (got.size() != 1) begin
            failures++; $display("FAIL t1_drain count=%0d exp=1", got.size());
        end else if (got[0] != 0) begin
            failures++; $display("FAIL t1_drain ch=%0d exp=0", got[0]);
        end
        checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL t1_vld_after got=%b exp=0", evt_vld); end
    endtask

    task automatic test_lock_drain();
        mode = '0;
        do_reset();
        set_mode(1, MODE_BOTH);
        for (int t = 0; t < 3; t++) begin
            async_in[1] = ~async_in[1];
            for (int c = 0; c < GAP; c++) begin
                tick();
                if (evt_vld) begin
                    checks++;
                    if (evt_ch !== 2'd1) begin failures++; $display("FAIL t2_hold_ch got=%0d exp=1", evt_ch); end
                end
            end
        end
        checks++; if (evt_vld !== 1'b1) begin failures++; $display("FAIL t2_vld got=%b exp=1", evt_vld); end
        evt_rdy = 1'b1;
        run(3);
        evt_rdy = 1'b0;
        checks++;
        if (got.size() != 3) begin
            failures++; $display("FAIL t2_drain count=%0d exp=3", got.size());
        end else if (got[0] != 1 || got[1] != 1 || got[2] != 1) begin
            failures++; $display("FAIL t2_drain chs=%0d,%0d,%0d exp=1,1,1", got[0], got[1], got[2]);
        end
        checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL t2_vld_after got=%b exp=0", evt_vld); end
    endtask

    task automatic test_round_robin();
        mode = '0;
        do_reset();
        set_mode(0, MODE_RISE);
        set_mode(2, MODE_RISE);
        set_mode(3, MODE_RISE);
        evt_rdy  = 1'b1;
        async_in = 4'b1101;
        run(SETTLE + 4);
        checks++;
        if (got.size() != 3) begin
            failures++; $display("FAIL t3_order count=%0d exp=3", got.size());
        end else if (got[0] != 0 || got[1] != 2 || got[2] != 3) begin
            failures++; $display("FAIL t3_order chs=%0d,%0d,%0d exp=0,2,3", got[0], got[1], got[2]);
        end
        checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL t3_vld got=%b exp=0", evt_vld); end
        async_in[0] = 1'b0;
        run(SETTLE);
        got.delete();
        async_in[0] = 1'b1;
        run(SETTLE + 2);
        evt_rdy = 1'b0;
        checks++;
        if (got.size() != 1) begin
            failures++; $display("FAIL t3_wrap count=%0d exp=1", got.size());
        end else if (got[0] != 0) begin
            failures++; $display("FAIL t3_wrap ch=%0d exp=0", got[0]);
        end
    endtask

    task automatic test_overflow();
        bit found;
        mode = '0;
        do_reset();
        set_mode(3, MODE_BOTH);
        for (int t = 0; t < 5; t++) begin
            async_in[3] = ~async_in[3];
            repeat (GAP) tick();
            checks++;
            if (ovf[3] !== (t >= 3)) begin
                failures++; $display("FAIL t4_ovf edge=%0d got=%b exp=%b", t + 1, ovf[3], (t >= 3));
            end
        end
        checks++; if (evt_ch !== 2'd3) begin failures++; $display("FAIL t4_ch got=%0d exp=3", evt_ch); end
        async_in[3] = ~async_in[3];
        found = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (evt_pul[3]) begin found = 1'b1; break; end
            tick();
        end
        checks++; if (!found) begin failures++; $display("FAIL t4_wait6 pulse not seen within %0d cycles", LAT + 4); end
        ovf_clr[3] = 1'b1;
        tick();
        ovf_clr[3] = 1'b0;
        checks++; if (ovf[3] !== 1'b1) begin failures++; $display("FAIL t4_set_wins got=%b exp=1", ovf[3]); end
        ovf_clr[3] = 1'b1;
        tick();
        ovf_clr[3] = 1'b0;
        checks++; if (ovf[3] !== 1'b0) begin failures++; $display("FAIL t4_clr got=%b exp=0", ovf[3]); end
        evt_rdy = 1'b1;
        got.delete();
        run(6);
        evt_rdy = 1'b0;
        checks++; if (got.size() != 3) begin failures++; $display("FAIL t4_sat count=%0d exp=3", got.size()); end
    endtask

    task automatic test_inc_grant_reset();
        bit found;
        mode = '0;
        do_reset();
        set_mode(2, MODE_BOTH);
        for (int t = 0; t < 2; t++) begin
            async_in[2] = ~async_in[2];
            repeat (GAP) tick();
        end
        async_in[2] = ~async_in[2];
        found = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (evt_pul[2]) begin found = 1'b1; break; end
            tick();
        end
        checks++; if (!found) begin failures++; $display("FAIL t5_wait pulse not seen within %0d cycles", LAT + 4); end
        evt_rdy = 1'b1;
        got.delete();
        run(1);
        run(4);
        evt_rdy = 1'b0;
        checks++; if (got.size() != 3) begin failures++; $display("FAIL t5_inc_grant handshakes=%0d exp=3", got.size()); end
        checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL t5_vld_drained got=%b exp=0", evt_vld); end
        for (int t = 0; t < 4; t++) begin
            async_in[2] = ~async_in[2];
            repeat (GAP) tick();
        end
        checks++; if (evt_vld !== 1'b1) begin failures++; $display("FAIL t5_pre_vld got=%b exp=1", evt_vld); end
        checks++; if (ovf[2] !== 1'b1)  begin failures++; $display("FAIL t5_pre_ovf got=%b exp=1", ovf[2]); end
        async_in[2] = ~async_in[2];
        repeat (LAT) tick();
        rst = 1'b1;
        async_in = '0;
        tick();
        checks++; if (evt_pul !== 4'b0) begin failures++; $display("FAIL t5_rst_pul got=%b exp=0000", evt_pul); end
        checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL t5_rst_vld got=%b exp=0", evt_vld); end
        checks++; if (ovf !== 4'b0)     begin failures++; $display("FAIL t5_rst_ovf got=%b exp=0000", ovf); end
        rst = 1'b0;
        run(SETTLE + 2);
        checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL t5_pend_zero vld=%b exp=0", evt_vld); end
    endtask

`ifdef PULSE_SYNC_MC_FILT_EN
    task automatic test_filter();
        mode = '0;
        do_reset();
        set_mode(0, MODE_RISE);
        async_in[0] = 1'b1;
        watch_pulse(0, 2, -1, 12, "t6_glitch");
        async_in[0] = 1'b1;
        watch_pulse(0, 4, SYNC_STG + FILT_CYC, SYNC_STG + FILT_CYC + 4, "t6_pass");
    endtask
`endif

    initial begin
        rst      = 1'b1;
        async_in = '0;
        mode     = '0;
        evt_rdy  = 1'b0;
        ovf_clr  = '0;
        test_reset();
        test_single();
        test_lock_drain();
        test_round_robin();
        test_overflow();
        test_inc_grant_reset();
`ifdef PULSE_SYNC_MC_FILT_EN
        test_filter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
